// File: rtl/rv_fetch_queue.sv
`timescale 1ns/1ps
// rv_fetch_queue: instruction-fetch front end. Owns the PC, buffers fetched
// {pc, inst} pairs in a DEPTH-entry queue for decode, applies execute-stage
// redirects and runs the HALT_DRAIN-cycle drain into HALTED on a halt request.
// Optional macro RV_FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
//
// Handshake: decode consumes the head on a cycle where dec_valid and dec_ready
// are both high; dec_valid never depends on dec_ready, and dec_inst/dec_pc are
// stable while dec_valid is high and dec_ready is low.
module rv_fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              HALT_DRAIN = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic [XLEN-1:0] inst_addr,
  input  logic [31:0]     inst,
  output logic            dec_valid,
  output logic [31:0]     dec_inst,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic            misalign_err
`ifdef RV_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int          PW   = $clog2(DEPTH);
  localparam int          DW   = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [DW-1:0]     drain_cnt;
  logic              misalign;
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];

  logic in_run;
  logic take_halt;
  logic take_redirect;
  logic flush;
  logic pop;
  logic push;

  // Per-cycle control: halt beats redirect, redirect beats push/pop.
  always_comb begin
    in_run        = (state == RUN);
    take_halt     = in_run & halt_req;
    take_redirect = in_run & ~halt_req & redirect_valid;
    flush         = take_halt | take_redirect;
    pop           = dec_valid & dec_ready;
    push          = in_run & ~flush & ((count != FULL) | pop);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_b) state <= RUN;
    else       state <= state_next;
  end

  // FSM next-state: RUN -> DRAIN on halt, DRAIN -> HALTED when the counter expires.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (halt_req) state_next = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // PC, queue pointers/occupancy, drain counter and sticky misalign flag.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drain_cnt <= '0;
      misalign  <= 1'b0;
    end else if (take_halt) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drain_cnt <= DW'(HALT_DRAIN - 1);
    end else if (take_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= {redirect_pc[XLEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
    end else if (in_run) begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc     <= pc + XLEN'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push & ~pop)      count <= count + (PW + 1)'(1);
      else if (pop & ~push) count <= count - (PW + 1)'(1);
    end else if ((state == DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - DW'(1);
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst_b && push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= inst;
    end
  end

`ifdef RV_FETCH_PERF_EN
  // Fetch and flush-discard counters; an entry popped in the flush cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)  perf_fetched <= perf_fetched + 32'd1;
      if (flush) perf_flushed <= perf_flushed + 32'(count) - 32'(pop);
    end
  end
`endif

  assign inst_addr    = pc;
  assign dec_valid    = in_run & (count != '0);
  assign dec_inst     = inst_mem[rd_ptr];
  assign dec_pc       = pc_mem[rd_ptr];
  assign halted       = (state == HALTED);
  assign misalign_err = misalign;

endmodule

// File: doc/rv_fetch_queue.md
# rv_fetch_queue

Parametrised instruction-fetch front end for the pipelined RISC-V core. It owns the PC and drives the instruction-memory address. Fetched {pc, inst} pairs are buffered in a DEPTH-entry queue and handed to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and performs the multi-cycle halt drain on ECALL. It replaces the hard-wired PC-hold stall, the fixed 4-stage halted delay chain and the single-slot instruction registers with one configurable block.

## Interface
Parameters:
- XLEN, 32, width of PC and address datapath.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.
- HALT_DRAIN, 4, cycles from accepted halt request to `halted`; ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_b  input  1  synchronous, active-high reset; 1 = reset.
- inst_addr  output  XLEN  fetch address (the PC register).
- inst  input  32  instruction memory data for `inst_addr`, valid in the same cycle.
- dec_valid  output  1  queue head is presented to decode.
- dec_inst  output  32  head instruction.
- dec_pc  output  XLEN  head PC.
- dec_ready  input  1  decode accepts the head this cycle.
- redirect_valid  input  1  taken branch/JAL/JALR from execute.
- redirect_pc  input  XLEN  redirect target.
- halt_req  input  1  ECALL/halt detected downstream.
- halted  output  1  sticky; core halted.
- misalign_err  output  1  sticky; a redirect target had bits [1:0] ≠ 0.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset enters RUN.
- **RUN, fetch (push):** a push occurs when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
  - On push, enqueue {inst_addr, inst} and set PC ← PC + 4, modulo 2^XLEN.
  - With no push, PC holds.
- **RUN, pop:** `dec_valid = (count != 0)` and the state is RUN. A pop is `dec_valid & dec_ready`.
  - Simultaneous push and pop leave `count` unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
- **RUN, redirect:** `redirect_valid` takes priority over push and pop.
  - Flush the queue: count ← 0 and pointers ← 0.
  - PC ← {redirect_pc[XLEN-1:2], 2'b00}. No push that cycle.
  - If redirect_pc[1:0] ≠ 0, set `misalign_err` ← 1. It stays set until reset.
- **halt_req in RUN:** takes priority over redirect.
  - Go to DRAIN, flush the queue, freeze the PC, and load the drain counter with HALT_DRAIN−1.
- **DRAIN:**
  - No push and `dec_valid` = 0.
  - `redirect_valid` and `halt_req` are ignored.
  - The counter decrements each cycle. At 0, go to HALTED.
- **HALTED:**
  - `halted` = 1. PC and queue are frozen; all inputs are ignored.
  - Only `rst_b` leaves this state.
- **Reset mid-operation:** at any state, reset returns every register to its reset value on the next edge.

## Timing
- Reset values:
  - inst_addr = RESET_PC.
  - dec_valid = 0, halted = 0, misalign_err = 0.
  - count = 0; state = RUN.
  - dec_inst and dec_pc are don't-care while dec_valid = 0.
- First push happens at the first edge with `rst_b` = 0.
- Fetch-to-decode latency is 1 cycle: an instruction pushed at edge k is visible on `dec_*` after edge k.
- Sustained throughput is 1 instruction per cycle while `dec_ready` = 1.
- With `dec_ready` = 0, the queue fills in DEPTH cycles, then the PC stalls.
- After a redirect sampled at edge k:
  - inst_addr = target after edge k.
  - dec_valid = 0 until edge k+1, and the first target instruction is presented after k+1.
- With `halt_req` sampled at edge k, `halted` rises after edge k+HALT_DRAIN. With HALT_DRAIN = 1, it rises after k+1.
- `dec_*`, `inst_addr`, `halted` and `misalign_err` are all driven from registers; there is no combinational path from inputs.

## Configuration
- Macro: `RV_FETCH_PERF_EN`.
- **Defined:** adds two output ports:
  - `perf_fetched` [31:0]: increments on each push.
  - `perf_flushed` [31:0]: adds the number of entries discarded at each redirect/halt flush.
  - Both reset to 0 and wrap at 2^32.
  - Entries discarded on flush are count − (1 if a pop occurs that same cycle).
- **Undefined:** ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, dec_ready = 1, imem returning addr-tagged words → dec_pc sequence 0, 4, 8, …; dec_valid = 1 from cycle 2; halted = 0.
- dec_ready = 0 for 10 cycles, DEPTH = 4 → inst_addr stops at 0x10, count = 4. Release dec_ready → pops in order 0, 4, 8, 0xC, 0x10 with no loss or duplication.
- redirect_valid with redirect_pc = 0x100 while the queue holds 3 entries → next cycle inst_addr = 0x100 and dec_valid = 0; the cycle after, dec_pc = 0x100. In RV_FETCH_PERF_EN build, perf_flushed += 3 (or 2 if dec_ready was 1 that cycle).
- redirect_pc = 0x102 → inst_addr = 0x100 and misalign_err = 1, still 1 after 20 further cycles.
- halt_req at cycle 50 with HALT_DRAIN = 4 → dec_valid = 0 from cycle 51; halted = 1 exactly from cycle 54; a redirect at cycle 52 has no effect.
- Same-cycle halt_req and redirect_valid → halt taken, PC unchanged. Then rst_b = 1 for 1 cycle while HALTED → all outputs return to reset values and fetching restarts at RESET_PC.
